// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lc3_mem_pkg : shared types and constants for the SRAM access controller  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lc3_mem_pkg;

  localparam int WORD_W     = 16;
  localparam int MAX_WAIT   = 15;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4,
    DONE      = 3'd5
  } mem_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } strobe_t;

  // SRAM pin levels that belong to each state; registered by the caller.
  function automatic strobe_t strobe_decode(input mem_state_t s);
    strobe_t v;
    v = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
    case (s)
      RD_STROBE: v = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
      WR_SETUP:  v = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
      WR_STROBE: v = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
      WR_HOLD:   v = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
      default:   v = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wait_timer : clear/enable counter flagging the last wait-state cycle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_wait_timer
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset_al,
  input  logic Clr,
  input  logic En,
  output logic Tc
);

  localparam logic [WAIT_CNT_W-1:0] c_TERMINAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] r_count;

  // Holding at terminal count means the counter can never wrap.
  always_ff @(posedge Clk) begin
    if (!Reset_al) begin
      r_count <= '0;
    end else if (Clr) begin
      r_count <= '0;
    end else if (En && !Tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign Tc = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_ctrl : MAR/MDR owner and wait-stated SRAM read/write sequencer|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int W           = WORD_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         Clk,
  input  logic         Reset_al,
  input  logic         LD_MAR,
  input  logic         LD_MDR,
  input  logic         MIO_EN,
  input  logic         Mem_req,
  input  logic         Mem_wr,
  input  logic [W-1:0] Data_from_dataBus,
  input  logic [W-1:0] Mem_rdata,
  output logic [W-1:0] MAR,
  output logic [W-1:0] Data_to_GateMDR,
  output logic [W-1:0] Mem_addr,
  output logic [W-1:0] Mem_wdata,
  output logic         Mem_ce_n,
  output logic         Mem_oe_n,
  output logic         Mem_we_n,
  output logic         Busy,
  output logic         Done
);

  logic [W-1:0] r_mar;
  logic [W-1:0] r_mdr;
  mem_state_t   r_state;
  mem_state_t   w_state_nxt;
  strobe_t      r_strobe;
  strobe_t      w_strobe_nxt;
  logic         w_tc;
  logic         w_tmr_clr;
  logic         w_tmr_en;
  logic         w_ld_mar;
  logic         w_ld_mdr;
  logic         w_rd_capture;

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .Clk      (Clk),
    .Reset_al (Reset_al),
    .Clr      (w_tmr_clr),
    .En       (w_tmr_en),
    .Tc       (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (Mem_req) begin
          w_state_nxt = Mem_wr ? WR_SETUP : RD_STROBE;
        end
      end
      RD_STROBE: if (w_tc) w_state_nxt = DONE;
      WR_SETUP:  w_state_nxt = WR_STROBE;
      WR_STROBE: if (w_tc) w_state_nxt = WR_HOLD;
      WR_HOLD:   w_state_nxt = DONE;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so pins change only on the clock edge.
  assign w_strobe_nxt = strobe_decode(w_state_nxt);

  assign w_tmr_clr    = (r_state == IDLE) || (w_state_nxt != r_state);
  assign w_tmr_en     = (r_state == RD_STROBE) || (r_state == WR_STROBE);

  // A request in the same IDLE cycle wins over LD_MAR so the access sees the old address.
  assign w_ld_mar     = (r_state == IDLE) && LD_MAR && !Mem_req;
  assign w_ld_mdr     = (r_state == IDLE) && LD_MDR && !MIO_EN;
  assign w_rd_capture = (r_state == RD_STROBE) && w_tc && MIO_EN;

  always_ff @(posedge Clk) begin
    if (!Reset_al) begin
      r_state  <= IDLE;
      r_strobe <= '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
      r_mar    <= '0;
      r_mdr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_strobe_nxt;
      if (w_ld_mar) begin
        r_mar <= Data_from_dataBus;
      end
      if (w_ld_mdr) begin
        r_mdr <= Data_from_dataBus;
      end else if (w_rd_capture) begin
        r_mdr <= Mem_rdata;
      end
    end
  end

  assign MAR             = r_mar;
  assign Mem_addr        = r_mar;
  assign Data_to_GateMDR = r_mdr;
  assign Mem_wdata       = r_mdr;
  assign Mem_ce_n        = r_strobe.ce_n;
  assign Mem_oe_n        = r_strobe.oe_n;
  assign Mem_we_n        = r_strobe.we_n;
  assign Busy            = (r_state != IDLE);
  assign Done            = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_ctrl : directed bench, WAIT_CYCLES=2 and WAIT_CYCLES=1     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_access_ctrl;

  logic        Clk;
  logic        Reset_al;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        Mem_req;
  logic        Mem_wr;
  logic [15:0] Data_from_dataBus;
  logic [15:0] Mem_rdata;

  logic [15:0] mar0, mdr0, addr0, wdata0;
  logic        ce0, oe0, we0, busy0, done0;
  logic [15:0] mar1, mdr1, addr1, wdata1;
  logic        ce1, oe1, we1, busy1, done1;

  int total;
  int bad;

  int          done_c[2];
  int          done_n[2];
  int          oe_lo[2];
  int          we_lo[2];
  int          ce_lo[2];
  int          we_first[2];
  int          stab_bad[2];
  logic [15:0] a0[2];
  logic [15:0] d0[2];

  mem_access_ctrl #(.W(16), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset_al(Reset_al), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .Mem_req(Mem_req), .Mem_wr(Mem_wr), .Data_from_dataBus(Data_from_dataBus),
    .Mem_rdata(Mem_rdata), .MAR(mar0), .Data_to_GateMDR(mdr0), .Mem_addr(addr0),
    .Mem_wdata(wdata0), .Mem_ce_n(ce0), .Mem_oe_n(oe0), .Mem_we_n(we0),
    .Busy(busy0), .Done(done0)
  );

  mem_access_ctrl #(.W(16), .WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset_al(Reset_al), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
    .Mem_req(Mem_req), .Mem_wr(Mem_wr), .Data_from_dataBus(Data_from_dataBus),
    .Mem_rdata(Mem_rdata), .MAR(mar1), .Data_to_GateMDR(mdr1), .Mem_addr(addr1),
    .Mem_wdata(wdata1), .Mem_ce_n(ce1), .Mem_oe_n(oe1), .Mem_we_n(we1),
    .Busy(busy1), .Done(done1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int i, input logic ce, input logic oe, input logic we,
                        input logic dn, input logic [15:0] a, input logic [15:0] d,
                        input int c);
    if (!oe) oe_lo[i]++;
    if (!ce) ce_lo[i]++;
    if (!we) begin
      we_lo[i]++;
      if (we_first[i] == 0) we_first[i] = c;
    end
    if (dn) begin
      done_n[i]++;
      if (done_c[i] == 0) done_c[i] = c;
    end
    if (!ce && (a !== a0[i] || d !== d0[i])) stab_bad[i]++;
  endtask

  // Issues one request at a negedge and observes 10 following cycles on both instances.
  task automatic do_access(input logic wr, input logic mio, input logic [15:0] rd,
                           input logic ld_mar, input logic [15:0] b, input logic lockout);
    Mem_req = 1'b1;
    Mem_wr = wr;
    MIO_EN = mio;
    Mem_rdata = rd;
    LD_MAR = ld_mar;
    LD_MDR = 1'b0;
    Data_from_dataBus = b;
    for (int i = 0; i < 2; i++) begin
      done_c[i] = 0; done_n[i] = 0; oe_lo[i] = 0; we_lo[i] = 0;
      ce_lo[i] = 0; we_first[i] = 0; stab_bad[i] = 0;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        a0[0] = addr0; d0[0] = wdata0;
        a0[1] = addr1; d0[1] = wdata1;
      end
      sample(0, ce0, oe0, we0, done0, addr0, wdata0, c);
      sample(1, ce1, oe1, we1, done1, addr1, wdata1, c);
      if (lockout && c == 1) begin
        LD_MAR = 1'b1;
        Data_from_dataBus = 16'hFFFF;
        Mem_req = 1'b1;
      end else begin
        LD_MAR = 1'b0;
        Mem_req = 1'b0;
      end
    end
  endtask

  initial begin
    int found;
    total = 0;
    bad = 0;
    Reset_al = 1'b0;
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
    MIO_EN = 1'b0;
    Mem_req = 1'b0;
    Mem_wr = 1'b0;
    Data_from_dataBus = '0;
    Mem_rdata = '0;

    repeat (2) @(negedge Clk);
    check("rst_mar", mar0, 16'h0000);
    check("rst_mdr", mdr0, 16'h0000);
    check("rst_ce_n", ce0, 1'b1);
    check("rst_oe_n", oe0, 1'b1);
    check("rst_we_n", we0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);

    Reset_al = 1'b1;
    LD_MAR = 1'b1;
    Data_from_dataBus = 16'h3000;
    @(negedge Clk);
    LD_MAR = 1'b0;
    check("ld_mar", mar0, 16'h3000);

    // Read with a second request and LD_MAR attempted while busy.
    do_access(1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1);
    check("rd_oe_cycles", oe_lo[0], 2);
    check("rd_done_cycle", done_c[0], 3);
    check("rd_done_count", done_n[0], 1);
    check("rd_mdr", mdr0, 16'hBEEF);
    check("lock_mar", mar0, 16'h3000);
    check("rd_busy_end", busy0, 1'b0);
    check("rd1_done_cycle", done_c[1], 2);
    check("rd1_oe_cycles", oe_lo[1], 1);
    check("rd1_mdr", mdr1, 16'hBEEF);

    LD_MAR = 1'b1;
    Data_from_dataBus = 16'h3001;
    @(negedge Clk);
    LD_MAR = 1'b0;
    LD_MDR = 1'b1;
    MIO_EN = 1'b0;
    Data_from_dataBus = 16'h1234;
    @(negedge Clk);
    LD_MDR = 1'b0;
    check("wr_pre_mar", mar0, 16'h3001);
    check("wr_pre_mdr", mdr0, 16'h1234);

    do_access(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("wr_we_cycles", we_lo[0], 2);
    check("wr_we_first", we_first[0], 2);
    check("wr_ce_cycles", ce_lo[0], 4);
    check("wr_oe_cycles", oe_lo[0], 0);
    check("wr_done_cycle", done_c[0], 5);
    check("wr_stable", stab_bad[0], 0);
    check("wr_addr", a0[0], 16'h3001);
    check("wr_wdata", d0[0], 16'h1234);
    check("wr1_done_cycle", done_c[1], 4);
    check("wr1_we_cycles", we_lo[1], 1);
    check("wr1_ce_cycles", ce_lo[1], 3);

    // Request and LD_MAR together; MIO_EN=0 read must leave MDR alone.
    do_access(1'b0, 1'b0, 16'h7777, 1'b1, 16'hABCD, 1'b0);
    check("req_ldmar_addr", a0[0], 16'h3001);
    check("req_ldmar_mar", mar0, 16'h3001);
    check("nomio_mdr", mdr0, 16'h1234);
    check("nomio_done_cycle", done_c[0], 3);
    check("nomio1_mdr", mdr1, 16'h1234);
    check("nomio1_done_cycle", done_c[1], 2);

    LD_MDR = 1'b1;
    MIO_EN = 1'b1;
    Data_from_dataBus = 16'h1111;
    @(negedge Clk);
    LD_MDR = 1'b0;
    check("ldmdr_mio_ignored", mdr0, 16'h1234);

    LD_MAR = 1'b1;
    LD_MDR = 1'b1;
    MIO_EN = 1'b0;
    Data_from_dataBus = 16'h5A5A;
    @(negedge Clk);
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
    check("dual_ld_mar", mar0, 16'h5A5A);
    check("dual_ld_mdr", mdr0, 16'h5A5A);

    // Abort a write during its strobe phase.
    Mem_req = 1'b1;
    Mem_wr = 1'b1;
    @(negedge Clk);
    Mem_req = 1'b0;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      if (we0 == 1'b0) found = 1;
      else @(negedge Clk);
    end
    check("rst_mid_found_strobe", found, 1);
    Reset_al = 1'b0;
    @(negedge Clk);
    check("rst_mid_we_n", we0, 1'b1);
    check("rst_mid_ce_n", ce0, 1'b1);
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_done", done0, 1'b0);
    check("rst_mid_mar", mar0, 16'h0000);
    Reset_al = 1'b1;
    repeat (2) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
